// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM shared-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefTimeout = 64;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StResp
  } arb_state_e;

endpackage

// File: rtl/arb_rr2_pick.sv
// Two-way alternating picker: a lone requester wins; on contention D wins unless D won last.
module arb_rr2_pick
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_d_i,
  output logic gnt_o,
  output logic valid_o
);

  always_comb begin
    valid_o = i_req_i | d_req_i;
    gnt_o   = REQ_I;
    if (d_req_i && (!i_req_i || !last_d_i)) begin
      gnt_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Optional bus timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_e        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              gnt_q, gnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_gnt, pick_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  arb_rr2_pick u_pick (
    .i_req_i (i_req_i),
    .d_req_i (d_req_i),
    .last_d_i(last_d_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    gnt_d       = gnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d     = pick_gnt;
          mem_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
          if (pick_gnt == REQ_D) begin
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            state_d     = StBusyD;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr_i;
            mem_wdata_d = '0;
            state_d     = StBusyI;
          end
        end
      end

      StBusyI, StBusyD: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = StResp;
          if (state_q == StBusyI) begin
            i_rdata_d = mem_rdata_i;
          end else begin
            // Stores return zero so the pipeline never sees stale memory data.
            d_rdata_d = mem_we_q ? '0 : mem_rdata_i;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          mem_req_d = 1'b0;
          state_d   = StResp;
          err_d     = 1'b1;
          if (state_q == StBusyI) begin
            i_rdata_d = '0;
          end else begin
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      StResp: begin
        last_d_d = (gnt_q == REQ_D);
        state_d  = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b0;
      gnt_q       <= REQ_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign err_o          = 1'b0;
`endif

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign i_ack_o     = (state_q == StResp) && (gnt_q == REQ_I);
  assign d_ack_o     = (state_q == StResp) && (gnt_q == REQ_D);
  assign stall_o     = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-table bench for mem_port_arbiter plus hand sequences for long/abort cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_req, mem_we, stall, err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .i_req_i    (i_req),
    .i_addr_i   (i_addr),
    .i_ack_o    (i_ack),
    .i_rdata_o  (i_rdata),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_ack_o    (d_ack),
    .d_rdata_o  (d_rdata),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .stall_o    (stall),
    .err_o      (err)
  );

  typedef struct {
    logic        rst, ireq;
    logic [31:0] ia;
    logic        dreq, dwe;
    logic [31:0] da, wd;
    logic        mack;
    logic [31:0] mr;
    logic        e_mreq, e_mwe;
    logic [31:0] e_ma;
    logic        chk_wd;
    logic [31:0] e_wd;
    logic        e_iack;
    logic [31:0] e_ir;
    logic        e_dack;
    logic [31:0] e_dr;
    logic        e_stall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, ireq, input logic [31:0] ia, input logic dreq, dwe,
                     input logic [31:0] da, wd, input logic mack, input logic [31:0] mr,
                     input logic emreq, emwe, input logic [31:0] ema, input logic chkwd,
                     input logic [31:0] ewd, input logic eiack, input logic [31:0] eir,
                     input logic edack, input logic [31:0] edr, input logic estall);
    vec_t v;
    v = '{r, ireq, ia, dreq, dwe, da, wd, mack, mr, emreq, emwe, ema, chkwd, ewd,
          eiack, eir, edack, edr, estall};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    //  rst ireq ia            dreq dwe da            wd            mack mr
    //  mreq mwe ma  chkwd wd  iack ir  dack dr  stall
    add(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    add(1, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    add(1, 1, 32'h10, 0, 0, 32'h0, 32'h0, 1, 32'h2001_0005,
        1, 0, 32'h10, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    add(1, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 1, 32'h2001_0005, 0, 32'h0, 0);
    add(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h2001_0005, 0, 32'h0, 0);
    // store 0x40 <- DEADBEEF, then load it back
    add(1, 0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h2001_0005, 0, 32'h0, 1);
    add(1, 0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF, 1, 32'h1234_5678,
        1, 1, 32'h40, 1, 32'hDEAD_BEEF, 0, 32'h2001_0005, 0, 32'h0, 1);
    add(1, 0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h2001_0005, 1, 32'h0, 0);
    add(1, 0, 32'h0, 1, 0, 32'h40, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h2001_0005, 0, 32'h0, 1);
    add(1, 0, 32'h0, 1, 0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF,
        1, 0, 32'h40, 0, 32'h0, 0, 32'h2001_0005, 0, 32'h0, 1);
    add(1, 0, 32'h0, 1, 0, 32'h40, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h2001_0005, 1, 32'hDEAD_BEEF, 0);
    // contention with last_d=1: I first, then D
    add(1, 1, 32'h20, 1, 0, 32'h44, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h2001_0005, 0, 32'hDEAD_BEEF, 1);
    add(1, 1, 32'h20, 1, 0, 32'h44, 32'h0, 1, 32'hAAAA_0001,
        1, 0, 32'h20, 0, 32'h0, 0, 32'h2001_0005, 0, 32'hDEAD_BEEF, 1);
    add(1, 1, 32'h20, 1, 0, 32'h44, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 1, 32'hAAAA_0001, 0, 32'hDEAD_BEEF, 1);
    add(1, 0, 32'h0, 1, 0, 32'h44, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'hAAAA_0001, 0, 32'hDEAD_BEEF, 1);
    add(1, 0, 32'h0, 1, 0, 32'h44, 32'h0, 1, 32'hBBBB_0002,
        1, 0, 32'h44, 0, 32'h0, 0, 32'hAAAA_0001, 0, 32'hDEAD_BEEF, 1);
    add(1, 0, 32'h0, 1, 0, 32'h44, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'hAAAA_0001, 1, 32'hBBBB_0002, 0);
    // reset with both requests held: D first after reset, then I
    add(0, 1, 32'h30, 1, 0, 32'h48, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'hAAAA_0001, 0, 32'hBBBB_0002, 1);
    add(1, 1, 32'h30, 1, 0, 32'h48, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    add(1, 1, 32'h30, 1, 0, 32'h48, 32'h0, 1, 32'hCCCC_0003,
        1, 0, 32'h48, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    add(1, 1, 32'h30, 1, 0, 32'h48, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'hCCCC_0003, 1);
    add(1, 1, 32'h30, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'hCCCC_0003, 1);
    add(1, 1, 32'h30, 0, 0, 32'h0, 32'h0, 1, 32'hDDDD_0004,
        1, 0, 32'h30, 0, 32'h0, 0, 32'h0, 0, 32'hCCCC_0003, 1);
    add(1, 1, 32'h30, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 1, 32'hDDDD_0004, 0, 32'hCCCC_0003, 0);
    // repeat contention: D first again
    add(1, 1, 32'h34, 1, 0, 32'h4C, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'hDDDD_0004, 0, 32'hCCCC_0003, 1);
    add(1, 1, 32'h34, 1, 0, 32'h4C, 32'h0, 0, 32'h0,
        1, 0, 32'h4C, 0, 32'h0, 0, 32'hDDDD_0004, 0, 32'hCCCC_0003, 1);
    add(1, 1, 32'h34, 1, 0, 32'h4C, 32'h0, 1, 32'hEEEE_0005,
        1, 0, 32'h4C, 0, 32'h0, 0, 32'hDDDD_0004, 0, 32'hCCCC_0003, 1);
    add(1, 1, 32'h34, 1, 0, 32'h4C, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'hDDDD_0004, 1, 32'hEEEE_0005, 1);
    add(1, 1, 32'h34, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'hDDDD_0004, 0, 32'hEEEE_0005, 1);
    add(1, 1, 32'h34, 0, 0, 32'h0, 32'h0, 1, 32'h1111_0006,
        1, 0, 32'h34, 0, 32'h0, 0, 32'hDDDD_0004, 0, 32'hEEEE_0005, 1);
    add(1, 1, 32'h34, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 1, 32'h1111_0006, 0, 32'hEEEE_0005, 0);
    // stray mem_ack_i in IDLE is ignored
    add(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h9999_9999,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h1111_0006, 0, 32'hEEEE_0005, 0);
    add(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
        0, 0, 32'h0, 0, 32'h0, 0, 32'h1111_0006, 0, 32'hEEEE_0005, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; i_req = tbl[i].ireq; i_addr = tbl[i].ia;
      d_req = tbl[i].dreq; d_we = tbl[i].dwe; d_addr = tbl[i].da; d_wdata = tbl[i].wd;
      mem_ack = tbl[i].mack; mem_rdata = tbl[i].mr;
      @(negedge clk);
      check($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, {31'b0, tbl[i].e_mreq});
      check($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      check($sformatf("v%0d_i_ack", i), {31'b0, i_ack}, {31'b0, tbl[i].e_iack});
      check($sformatf("v%0d_d_ack", i), {31'b0, d_ack}, {31'b0, tbl[i].e_dack});
      check($sformatf("v%0d_i_rdata", i), i_rdata, tbl[i].e_ir);
      check($sformatf("v%0d_d_rdata", i), d_rdata, tbl[i].e_dr);
      check($sformatf("v%0d_err", i), {31'b0, err}, 32'h0);
      if (tbl[i].e_mreq) begin
        check($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_mwe});
        check($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_ma);
      end
      if (tbl[i].chk_wd) check($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_wd);
      next_cycle();
    end

`ifndef MEM_ARB_TIMEOUT_EN
    // Slow memory: 20 BUSY cycles with no ack, everything must hold
    idle_inputs();
    d_req = 1; d_addr = 32'h50;
    @(negedge clk);
    check("slow_pre_req", {31'b0, mem_req}, 32'h0);
    next_cycle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("slow_req_%0d", k), {31'b0, mem_req}, 32'h1);
      check($sformatf("slow_addr_%0d", k), mem_addr, 32'h50);
      check($sformatf("slow_stall_%0d", k), {31'b0, stall}, 32'h1);
      check($sformatf("slow_noack_%0d", k), {31'b0, d_ack}, 32'h0);
      next_cycle();
    end
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("slow_req_at_ack", {31'b0, mem_req}, 32'h1);
    next_cycle();
    mem_ack = 0; mem_rdata = 0;
    @(negedge clk);
    check("slow_ack", {31'b0, d_ack}, 32'h1);
    check("slow_rdata", d_rdata, 32'h5555_AAAA);
    check("slow_stall_ack", {31'b0, stall}, 32'h0);
    next_cycle();
    d_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("slow_single_ack_%0d", k), {29'b0, d_ack, i_ack, mem_req}, 32'h0);
      next_cycle();
    end
`endif

    // Reset while BUSY_D: transaction abandoned, no ack, then a fresh store completes
    idle_inputs();
    d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'h0000_600D;
    next_cycle();
    @(negedge clk);
    check("rst_busy_req", {31'b0, mem_req}, 32'h1);
    rst = 0; d_req = 0; d_we = 0;
    next_cycle();
    rst = 1;
    @(negedge clk);
    check("rst_drop_req", {31'b0, mem_req}, 32'h0);
    check("rst_no_ack", {31'b0, d_ack}, 32'h0);
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    next_cycle();
    mem_ack = 0;
    @(negedge clk);
    check("rst_idle_no_ack", {30'b0, d_ack, mem_req}, 32'h0);
    d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'h0000_600D;
    next_cycle();
    @(negedge clk);
    check("rst_retry_req", {31'b0, mem_req}, 32'h1);
    check("rst_retry_we", {31'b0, mem_we}, 32'h1);
    check("rst_retry_addr", mem_addr, 32'h60);
    check("rst_retry_wdata", mem_wdata, 32'h0000_600D);
    mem_ack = 1; mem_rdata = 32'h1234_0000;
    next_cycle();
    mem_ack = 0;
    @(negedge clk);
    check("rst_retry_ack", {31'b0, d_ack}, 32'h1);
    check("rst_retry_rdata", d_rdata, 32'h0);
    next_cycle();
    d_req = 0; d_we = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: 8 BUSY cycles, then ack with zero data and an err pulse
    i_req = 1; i_addr = 32'h70;
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("to_busy_req_%0d", k), {31'b0, mem_req}, 32'h1);
      check($sformatf("to_busy_noack_%0d", k), {30'b0, i_ack, err}, 32'h0);
      next_cycle();
    end
    @(negedge clk);
    check("to_ack", {31'b0, i_ack}, 32'h1);
    check("to_err", {31'b0, err}, 32'h1);
    check("to_rdata", i_rdata, 32'h0);
    check("to_req_drop", {31'b0, mem_req}, 32'h0);
    next_cycle();
    i_req = 0;
    @(negedge clk);
    check("to_after", {29'b0, err, i_ack, mem_req}, 32'h0);
    next_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, variable-latency backing memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage pipeline. It grants one requester at a time and drives the memory handshake. It returns read data with a one-cycle ack and raises a pipeline stall while any request is outstanding. It sits between Instruction_Memory/Data_Memory users and the shared memory model; stall_o feeds the PC/IFID/IDEX/EXMEM/MEMWB write enables alongside hazard detection.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 64, max cycles waiting for mem_ack_i (used only with the optional feature)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
i_req_i  in  1  fetch request, held high until i_ack_o
i_addr_i  in  ADDR_W  fetch address
i_ack_o  out  1  one-cycle fetch completion
i_rdata_o  out  DATA_W  fetch data, valid with i_ack_o
d_req_i  in  1  data request, held high until d_ack_o
d_we_i  in  1  1=store, 0=load
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_ack_o  out  1  one-cycle data completion
d_rdata_o  out  DATA_W  load data, valid with d_ack_o
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion, one cycle
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
stall_o  out  1  pipeline stall
err_o  out  1  timeout error pulse (0 without the optional feature)

Behaviour:
- Reset: clk_i only, rst_i low at a rising edge. State=IDLE; last_d=0. All outputs 0 (acks, rdata, mem_req_o/we/addr/wdata, err_o). stall_o is combinational and follows the rule below.
- Reset mid-transaction: the arbiter abandons the transaction and drops mem_req_o next cycle. No ack is issued.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, one pending requester: grant it.
- IDLE, both pending: grant D if last_d=0, else grant I. The first contention after reset therefore goes to D. Consecutive contention alternates.
- On grant: register addr, we and wdata into mem_*_o, assert mem_req_o, go to BUSY_x. I-side grants force mem_we_o=0.
- BUSY_x: hold mem_req_o and all mem_* stable until mem_ack_i. On mem_ack_i, capture mem_rdata_i, drop mem_req_o, go to RESP. mem_ack_i in IDLE/RESP is ignored.
- RESP: pulse x_ack_o for exactly one cycle with x_rdata_o = captured data. For stores, d_rdata_o = 0. Set last_d = (granted==D). Go to IDLE.
- Latency: request seen in IDLE at cycle N; mem_req_o high at N+1; with mem_ack_i at N+1, x_ack_o at N+2. Minimum 3 edges from sample to ack. Back-to-back throughput: one transaction per 3 cycles minimum.
- A new grant is never issued in the RESP cycle. The requester deasserts req the cycle after ack or issues a new request.
- stall_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o).
- A requester dropping req before ack is a protocol violation. The transaction still completes, and the ack pulses harmlessly.
- rdata outputs hold their value until the next RESP for that side.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined: a counter clears on grant and increments each BUSY cycle without mem_ack_i. When it reaches TIMEOUT-1, the arbiter drops mem_req_o, goes to RESP, pulses x_ack_o with rdata=0, and pulses err_o in the same cycle.
- Undefined: no counter; BUSY waits indefinitely; err_o tied 0.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D, RESP), requester id constants (REQ_I=0, REQ_D=1), default widths.
- One sub-module arb_rr2_pick: combinational 2-way picker (reqs, last_d -> grant id, valid).
- The top holds the FSM, registers and the optional counter.

Test Plan:
- Single fetch: i_req_i=1, addr 0x0000_0010; memory acks 1 cycle after mem_req_o with 0x2001_0005 -> mem_we_o=0, mem_addr_o=0x10, i_ack_o one cycle with i_rdata_o=0x2001_0005; stall_o high until the ack cycle.
- Store then load: d store 0x40 <- 0xDEAD_BEEF, then load 0x40 -> mem_we_o=1 with wdata 0xDEAD_BEEF; the load returns 0xDEAD_BEEF; d_rdata_o=0 on the store ack.
- Contention: i_req and d_req both high from reset, held -> D served first, then I. Repeat contention after both are served -> D first again. Contention with last_d=1 -> I first.
- Slow memory: mem_ack_i delayed 20 cycles -> mem_req/addr stable all 20 cycles; exactly one ack; stall_o high throughout.
- Reset mid-BUSY_D: assert rst_i=0 for one edge -> mem_req_o=0 next cycle, no d_ack_o, state IDLE; a re-presented request completes normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=8, memory never acks -> after 8 BUSY cycles, ack with rdata=0 and err_o pulse; arbiter returns to IDLE.
